// File: rtl/apb_master_pkg.sv
// Shared types for the APB command master.
// FSM state encoding and the registered response bundle.
package apb_master_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_e;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        timeout;
    } apb_rsp_t;

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating ACCESS-phase wait counter for the APB command master.
// expired flags the last permitted wait cycle; constant 0 when disabled.
module apb_wait_timer
    import apb_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_WIDTH      = (TIMEOUT_CYCLES < 1) ? 1
                                 : $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic HCLK,
    input  logic HRESET,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [CNT_WIDTH-1:0] LAST =
        CNT_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    logic [CNT_WIDTH-1:0] cnt;

    always_ff @(posedge HCLK) begin
        if (HRESET || clear) begin
            cnt <= '0;
        end else if (enable && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

    if (TIMEOUT_CYCLES == 0) begin : g_off
        assign expired = 1'b0;
    end else begin : g_on
        assign expired = (cnt == LAST);
    end

endmodule

// File: rtl/apb_cmd_master.sv
// APB3 initiator: one valid/ready command becomes one APB transfer
// and yields exactly one registered response beat.
module apb_cmd_master
    import apb_master_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_WIDTH      = (TIMEOUT_CYCLES < 1) ? 1
                                 : $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [APB_ADDR_WIDTH-1:0] req_addr_i,
    input  logic [31:0]               req_wdata_i,
    input  logic                      req_write_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [31:0]               rsp_rdata_o,
    output logic                      rsp_err_o,
    output logic                      rsp_timeout_o,
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]               PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic [31:0]               PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    apb_state_e state, state_n;
    apb_rsp_t   rsp_q;
    logic       accept, done, abort, expired;

    // A held response must drain (possibly this cycle) before a new accept.
    assign req_ready_o = !HRESET && (state == IDLE)
                       && (!rsp_valid_o || rsp_ready_i);

    assign rsp_rdata_o   = rsp_q.rdata;
    assign rsp_err_o     = rsp_q.err;
    assign rsp_timeout_o = rsp_q.timeout;

    apb_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_WIDTH      (CNT_WIDTH)
    ) u_timer (
        .HCLK    (HCLK),
        .HRESET  (HRESET),
        .clear   (state == SETUP),
        .enable  ((state == ACCESS) && !PREADY),
        .expired (expired)
    );

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        done    = 1'b0;
        abort   = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_valid_i && req_ready_o) begin
                    accept  = 1'b1;
                    state_n = SETUP;
                end
            end
            SETUP: state_n = ACCESS;
            ACCESS: begin
                // PREADY in the expiry cycle still completes normally.
                if (PREADY) begin
                    done    = 1'b1;
                    state_n = IDLE;
                end else if (expired) begin
                    abort   = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state       <= IDLE;
            PADDR       <= '0;
            PWDATA      <= '0;
            PWRITE      <= 1'b0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_q       <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                PADDR  <= req_addr_i;
                PWDATA <= req_wdata_i;
                PWRITE <= req_write_i;
                PSEL   <= 1'b1;
            end
            if (state == SETUP) begin
                PENABLE <= 1'b1;
            end
            if (done || abort) begin
                PSEL    <= 1'b0;
                PENABLE <= 1'b0;
            end
            if (done) begin
                rsp_valid_o <= 1'b1;
                rsp_q <= '{rdata:   (PWRITE ? 32'h0 : PRDATA),
                           err:     PSLVERR,
                           timeout: 1'b0};
            end else if (abort) begin
                rsp_valid_o <= 1'b1;
                rsp_q <= '{rdata: 32'h0, err: 1'b1, timeout: 1'b1};
            end else if (rsp_valid_o && rsp_ready_i) begin
                rsp_valid_o <= 1'b0;
                rsp_q       <= '0;
            end
        end
    end

endmodule

// File: doc/apb_cmd_master.md
Name: apb_cmd_master

Overview:
APB initiator that turns a simple valid/ready command stream into single APB3 transfers. It is the counterpart to our APB slave peripherals, such as the event/interrupt service units, and lets a DMA-style or debug sequencer program them without a core. Only one transfer is outstanding at a time. Each transfer returns exactly one response beat, with read data, a slave error flag and a timeout flag.

Parameters:
APB_ADDR_WIDTH, 12, width of PADDR and req_addr_i (4KB slave window by default)
TIMEOUT_CYCLES, 255, ACCESS-phase wait cycles before abort; 0 disables the timeout
CNT_WIDTH, $clog2(TIMEOUT_CYCLES+1) (min 1), width of the wait counter (derived, do not override)

Ports:
HCLK  in  1  clock, all logic on rising edge
HRESET  in  1  synchronous reset, active-high
req_valid_i  in  1  command valid
req_ready_o  out  1  command accepted when valid&&ready
req_addr_i  in  APB_ADDR_WIDTH  byte address
req_wdata_i  in  32  write data
req_write_i  in  1  1=write, 0=read
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response consumed when valid&&ready
rsp_rdata_o  out  32  read data (0 for writes/timeouts)
rsp_err_o  out  1  PSLVERR seen or timeout
rsp_timeout_o  out  1  transfer aborted by timeout
PADDR  out  APB_ADDR_WIDTH  APB address
PWDATA  out  32  APB write data
PWRITE  out  1  APB direction
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PRDATA  in  32  APB read data
PREADY  in  1  APB ready
PSLVERR  in  1  APB slave error

Behaviour:
- Reset (sync, HRESET=1 at edge): state=IDLE; every output 0, including PADDR/PWDATA/PWRITE/PSEL/PENABLE/rsp_*; req_ready_o=0 while HRESET is high; wait counter 0.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - req_ready_o = !HRESET && (!rsp_valid_o || rsp_ready_i). This is combinational, and a pending response may drain in the same cycle a new request is accepted.
  - On accept: register addr/wdata/write into PADDR/PWDATA/PWRITE, set PSEL=1, go to SETUP.
  - With no request, PSEL=PENABLE=0.
- SETUP (exactly 1 cycle): PSEL=1, PENABLE=0. Next state ACCESS with PENABLE=1 and wait counter cleared.
- ACCESS, PREADY=1:
  - Complete the transfer and drop PSEL/PENABLE on the next edge; return to IDLE.
  - rsp_valid_o=1; rsp_rdata_o = PWRITE ? 0 : PRDATA; rsp_err_o = PSLVERR; rsp_timeout_o = 0.
- ACCESS, PREADY=0:
  - Stay in ACCESS; PSEL/PENABLE/PADDR/PWDATA/PWRITE held stable; counter increments, saturating.
  - If TIMEOUT_CYCLES != 0 and the counter equals TIMEOUT_CYCLES-1 in this cycle: abort. PSEL=PENABLE=0 next edge; rsp_valid_o=1, rsp_err_o=1, rsp_timeout_o=1, rdata=0; go to IDLE.
  - A PREADY=1 arriving in the abort cycle wins (normal completion).
- Latency: accept at edge N → SETUP during N+1 → ACCESS from N+2. With zero wait states, rsp_valid_o rises after edge N+3. That is 3 cycles request-to-response; back-to-back throughput is 1 transfer per 3 cycles.
- Response hold:
  - rsp_* registered and stable while rsp_valid_o && !rsp_ready_i; clears on handshake.
  - A new transfer cannot start while an unconsumed response is held (single-entry response register, no overwrite).
- Idle bus outputs: PADDR/PWDATA/PWRITE keep their last values between transfers; only PSEL/PENABLE return to 0.
- PRDATA and PSLVERR are sampled only when PSEL&&PENABLE&&PREADY, and ignored otherwise.
- Reset mid-transfer: PSEL/PENABLE are 0 after the reset edge, no response is produced, and any held response is discarded.
- Address is passed through unmodified; alignment is the requester's responsibility.

Decomposition:
- Package apb_master_pkg:
  - state enum apb_state_e {IDLE, SETUP, ACCESS};
  - packed struct apb_rsp_t {rdata[31:0], err, timeout}.
- Sub-module apb_wait_timer:
  - ports clear/enable/expired;
  - saturating CNT_WIDTH counter plus TIMEOUT_CYCLES compare;
  - expired is tied to 0 when TIMEOUT_CYCLES=0.
- FSM and response register live in apb_cmd_master.

Test Plan:
- Write 0x04 ← 0xDEADBEEF, PREADY=1 always → PSEL high 2 cycles, PENABLE 1 cycle, PWDATA stable; rsp_valid 3 cycles after accept with err=0, rdata=0.
- Read 0x08, slave inserts 3 wait states then PRDATA=0x0000_00A5 → ACCESS lasts 4 cycles with address held; rsp_rdata=0xA5 and err=0.
- Read with PSLVERR=1 at PREADY → rsp_err=1, rsp_timeout=0, rdata=PRDATA as sampled.
- TIMEOUT_CYCLES=4, PREADY stuck 0 → abort after 4 ACCESS cycles; PSEL/PENABLE drop, rsp err=1, timeout=1, rdata=0. Repeat with PREADY=1 in the 4th cycle → normal completion.
- Backpressure: hold rsp_ready_i=0 for 5 cycles with req_valid_i=1 → req_ready_o=0, PSEL=0, response stable. Release → accept in that same cycle, next transfer starts.
- Assert HRESET during ACCESS of a pending read → after the edge all outputs 0, no rsp_valid; a subsequent write completes normally.
